// File: rtl/lut3_pkg.sv
// Shared constants and helpers for the 3-input LUT evaluator array.
// LUT3_RESET_TT : truth table for y = d & (b | ~c), used as the power-on function.
// lut3_idx      : maps operands {b,c,d} to a truth-table bit index (4b + 2c + d).
package lut3_pkg;

  localparam logic [7:0] LUT3_RESET_TT = 8'hA2;

  function automatic logic [2:0] lut3_idx(input logic b, input logic c, input logic d);
    return {b, c, d};
  endfunction

endpackage

// File: rtl/lut3_cell.sv
// One channel's combinational 3-input lookup.
// Ports:
//   tt_i        8-bit truth table
//   b_i/c_i/d_i operands
//   y_o         tt_i[{b_i,c_i,d_i}]
module lut3_cell
  import lut3_pkg::*;
(
  input  logic [7:0] tt_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic       d_i,
  output logic       y_o
);

  assign y_o = tt_i[lut3_idx(b_i, c_i, d_i)];

endmodule

// File: rtl/lut3_logic_array.sv
// CHANNELS independent programmable 3-input logic evaluators with a registered
// valid/ready output stage and per-channel saturating rising-edge counters.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake for the b/c/d operand vectors
//   b, c, d               operand vectors, bit i feeds channel i
//   out_valid/out_ready   output handshake for y
//   y                     registered results
//   cfg_we/cfg_ch/cfg_tt  truth-table write port
//   cnt_clr               synchronous clear of all event counters
//   evt_cnt               counters, channel i at [i*CNT_W +: CNT_W]
module lut3_logic_array
  import lut3_pkg::*;
#(
  parameter int unsigned  CHANNELS = 4,
  parameter int unsigned  CNT_W    = 8,
  parameter logic [7:0]   RESET_TT = LUT3_RESET_TT,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS-1:0]       b,
  input  logic [CHANNELS-1:0]       c,
  input  logic [CHANNELS-1:0]       d,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS-1:0]       y,
  input  logic                      cfg_we,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic [7:0]                cfg_tt,
  input  logic                      cnt_clr,
  output logic [CHANNELS*CNT_W-1:0] evt_cnt
);

  logic                accept;
  logic [CHANNELS-1:0] y_new;

  logic [7:0]          tt_q  [CHANNELS];
  logic [7:0]          tt_d  [CHANNELS];
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic                out_valid_q, out_valid_d;
  logic [CHANNELS-1:0] y_q, y_d;
  logic [CHANNELS-1:0] prev_q, prev_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
    lut3_cell u_cell (
      .tt_i (tt_q[i]),
      .b_i  (b[i]),
      .c_i  (c[i]),
      .d_i  (d[i]),
      .y_o  (y_new[i])
    );
  end

  // Lookups read tt_q, so a same-cycle config write only affects later samples.
  always_comb begin
    tt_d = tt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        tt_d[i] = cfg_tt;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    prev_d      = prev_q;
    if (accept) begin
      out_valid_d = 1'b1;
      y_d         = y_new;
      prev_d      = y_new;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear dominates a coincident increment; counters stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cnt_clr) begin
        cnt_d[i] = '0;
      end else if (accept && y_new[i] && !prev_q[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      prev_q      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        tt_q[i]  <= RESET_TT;
        cnt_q[i] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      prev_q      <= prev_d;
      for (int i = 0; i < CHANNELS; i++) begin
        tt_q[i]  <= tt_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;

  always_comb begin
    evt_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      evt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

endmodule
